// File: rtl/CC_ITF_PKG.sv
// Shared 32-bit reqrsp channel types: request/response payloads and their handshake wrappers.
package CC_ITF_PKG;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic [3:0]  strb;
  } reqrsp_d32_q_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } reqrsp_d32_p_t;

  typedef struct packed {
    reqrsp_d32_q_t q;
    logic          q_valid;
    logic          p_ready;
  } reqrsp_d32_req_t;

  typedef struct packed {
    logic          q_ready;
    reqrsp_d32_p_t p;
    logic          p_valid;
  } reqrsp_d32_resps_t;

endpackage

// File: rtl/reqrsp_d32_arb_if.sv
// Bundle of the NUM_INP upstream reqrsp ports plus the single downstream port of the arbiter.
interface reqrsp_d32_arb_if #(
  parameter int NUM_INP = 3
);
  import CC_ITF_PKG::*;

  reqrsp_d32_req_t   [NUM_INP-1:0] slv_req_i;
  reqrsp_d32_resps_t [NUM_INP-1:0] slv_rsp_o;
  reqrsp_d32_req_t                 mst_req_o;
  reqrsp_d32_resps_t               mst_rsp_i;

  modport slave (
    input  slv_req_i,
    output slv_rsp_o,
    output mst_req_o,
    input  mst_rsp_i
  );

  modport master (
    output slv_req_i,
    input  slv_rsp_o,
    input  mst_req_o,
    output mst_rsp_i
  );

endinterface

// File: rtl/reqrsp_d32_arb.sv
// Round-robin N:1 reqrsp arbiter; request and response paths are combinational (0 cycles).
// Backpressure: downstream q_ready stall locks the grant; owner-ID FIFO full blocks new requests.
module reqrsp_d32_arb #(
  parameter int NUM_INP         = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  reqrsp_d32_arb_if.slave                    bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               unexpected_rsp_o
);

  localparam int IDX_W = $clog2(NUM_INP);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] sel_q;
  logic             lock_q;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] head;

  logic [IDX_W-1:0] id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic full;
  logic empty;
  logic mst_q_vld;
  logic mst_p_rdy;
  logic push;
  logic pop;

  // Scan downward so the input closest after the pointer is the last (winning) assignment.
  always_comb begin
    cand     = '0;
    scan_idx = '0;
    for (int k = NUM_INP; k >= 1; k--) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_INP);
      if (bus.slv_req_i[scan_idx].q_valid) begin
        cand = scan_idx;
      end
    end
  end

  assign full  = (cnt_q == CNT_MAX);
  assign empty = (cnt_q == '0);
  assign sel   = lock_q ? sel_q : cand;
  assign head  = id_mem[rd_ptr_q];

  assign mst_q_vld        = !rst_i && bus.slv_req_i[sel].q_valid && !full;
  assign push             = mst_q_vld && bus.mst_rsp_i.q_ready;
  assign mst_p_rdy        = empty ? 1'b1 : bus.slv_req_i[head].p_ready;
  assign pop              = !rst_i && bus.mst_rsp_i.p_valid && mst_p_rdy && !empty;
  assign unexpected_rsp_o = !rst_i && bus.mst_rsp_i.p_valid && empty;
  assign outstanding_o    = cnt_q;

  always_comb begin
    bus.mst_req_o.q       = bus.slv_req_i[sel].q;
    bus.mst_req_o.q_valid = mst_q_vld;
    bus.mst_req_o.p_ready = mst_p_rdy;
    for (int i = 0; i < NUM_INP; i++) begin
      bus.slv_rsp_o[i].q_ready = 1'b0;
      bus.slv_rsp_o[i].p       = bus.mst_rsp_i.p;
      bus.slv_rsp_o[i].p_valid = 1'b0;
    end
    bus.slv_rsp_o[sel].q_ready  = !rst_i && bus.mst_rsp_i.q_ready && !full;
    bus.slv_rsp_o[head].p_valid = !rst_i && bus.mst_rsp_i.p_valid && !empty;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= LAST_IDX;
      sel_q    <= '0;
      lock_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      // A presented but unaccepted request pins the grant so the payload stays stable.
      lock_q <= mst_q_vld && !bus.mst_rsp_i.q_ready;
      sel_q  <= sel;
      if (push) begin
        rr_ptr_q <= sel;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_reqrsp_d32_arb.sv
// Directed bench for reqrsp_d32_arb: arbitration order, lock, full, response routing, reset.
module tb_reqrsp_d32_arb;
  import CC_ITF_PKG::*;

  localparam int NUM_INP = 3;
  localparam int MAX_OUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] outstanding;
  logic       unexpected;
  int         checks   = 0;
  int         failures = 0;

  reqrsp_d32_arb_if #(.NUM_INP(NUM_INP)) bus ();

  reqrsp_d32_arb #(
    .NUM_INP         (NUM_INP),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .bus              (bus),
    .outstanding_o    (outstanding),
    .unexpected_rsp_o (unexpected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NUM_INP; i++) begin
      bus.slv_req_i[i[1:0]]         = '0;
      bus.slv_req_i[i[1:0]].p_ready = 1'b1;
    end
    bus.mst_rsp_i         = '0;
    bus.mst_rsp_i.q_ready = 1'b1;
  endtask

  task automatic req(input logic [1:0] idx, input logic [31:0] addr);
    bus.slv_req_i[idx].q_valid = 1'b1;
    bus.slv_req_i[idx].q.addr  = addr;
    bus.slv_req_i[idx].q.write = 1'b1;
    bus.slv_req_i[idx].q.data  = addr ^ 32'hA5A5_0000;
    bus.slv_req_i[idx].q.strb  = 4'hF;
  endtask

  task automatic rsp(input logic vld, input logic [31:0] data);
    bus.mst_rsp_i.p_valid = vld;
    bus.mst_rsp_i.p.data  = data;
    bus.mst_rsp_i.p.error = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] prev;

    // Reset cycle: outputs quiet even with upstream and downstream activity.
    rst = 1'b1;
    idle();
    req(2'd0, 32'h40);
    rsp(1'b1, 32'h1);
    tick();
    #1;
    chk1("rst_mst_qvld", bus.mst_req_o.q_valid, 1'b0);
    chk1("rst_qrdy0", bus.slv_rsp_o[0].q_ready, 1'b0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk1("rst_unexpected", unexpected, 1'b0);
    chk1("rst_pvld", bus.slv_rsp_o[0].p_valid | bus.slv_rsp_o[1].p_valid | bus.slv_rsp_o[2].p_valid, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk1("idle_mst_qvld", bus.mst_req_o.q_valid, 1'b0);
    chk1("idle_mst_prdy", bus.mst_req_o.p_ready, 1'b1);

    // Single requester on input 1, 2-cycle response latency.
    tick();
    req(2'd1, 32'h100);
    #1;
    chk1("s1_qvld", bus.mst_req_o.q_valid, 1'b1);
    chk("s1_addr0", bus.mst_req_o.q.addr, 32'h100);
    chk("s1_data0", bus.mst_req_o.q.data, 32'hA5A5_0100);
    chk1("s1_qrdy1", bus.slv_rsp_o[1].q_ready, 1'b1);
    chk1("s1_qrdy0", bus.slv_rsp_o[0].q_ready, 1'b0);
    tick();
    req(2'd1, 32'h104);
    #1;
    chk("s1_addr1", bus.mst_req_o.q.addr, 32'h104);
    chk("s1_out1", 32'(outstanding), 32'd1);
    tick();
    req(2'd1, 32'h108);
    rsp(1'b1, 32'hD100);
    #1;
    chk("s1_out_peak", 32'(outstanding), 32'd2);
    chk1("s1_pvld1_a", bus.slv_rsp_o[1].p_valid, 1'b1);
    chk("s1_pdata_a", bus.slv_rsp_o[1].p.data, 32'hD100);
    chk1("s1_pvld0", bus.slv_rsp_o[0].p_valid, 1'b0);
    chk1("s1_pvld2", bus.slv_rsp_o[2].p_valid, 1'b0);
    tick();
    bus.slv_req_i[1].q_valid = 1'b0;
    rsp(1'b1, 32'hD104);
    #1;
    chk("s1_out_b", 32'(outstanding), 32'd2);
    chk1("s1_pvld1_b", bus.slv_rsp_o[1].p_valid, 1'b1);
    tick();
    rsp(1'b1, 32'hD108);
    #1;
    chk("s1_out_c", 32'(outstanding), 32'd1);
    chk1("s1_pvld1_c", bus.slv_rsp_o[1].p_valid, 1'b1);
    tick();
    rsp(1'b0, 32'h0);
    #1;
    chk("s1_out_end", 32'(outstanding), 32'd0);
    chk1("s1_unexp", unexpected, 1'b0);

    // Contention after reset: grants 0,1,2,0,1,2 with each response one cycle later.
    tick();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      g    = 2'(k % 3);
      prev = 2'((k + 2) % 3);
      req(2'd0, 32'h200);
      req(2'd1, 32'h204);
      req(2'd2, 32'h208);
      rsp(k > 0, 32'hE000 + 32'(k));
      #1;
      chk("rr_addr", bus.mst_req_o.q.addr, 32'h200 + 32'(g) * 4);
      chk1("rr_qrdy_grant", bus.slv_rsp_o[g].q_ready, 1'b1);
      chk1("rr_qrdy_other", bus.slv_rsp_o[2'((k + 1) % 3)].q_ready, 1'b0);
      if (k > 0) begin
        chk1("rr_pvld_owner", bus.slv_rsp_o[prev].p_valid, 1'b1);
        chk1("rr_pvld_other", bus.slv_rsp_o[g].p_valid, 1'b0);
        chk("rr_out", 32'(outstanding), 32'd1);
      end
      tick();
    end
    idle();
    rsp(1'b1, 32'hE006);
    #1;
    chk1("rr_last_pvld2", bus.slv_rsp_o[2].p_valid, 1'b1);
    chk1("rr_last_pvld0", bus.slv_rsp_o[0].p_valid, 1'b0);
    tick();
    rsp(1'b0, 32'h0);
    #1;
    chk("rr_out_end", 32'(outstanding), 32'd0);

    // Backpressure lock on input 2 while input 0 also requests.
    bus.mst_rsp_i.q_ready = 1'b0;
    req(2'd2, 32'h1000);
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) req(2'd0, 32'h2000);
      #1;
      chk("lk_addr", bus.mst_req_o.q.addr, 32'h1000);
      chk1("lk_qvld", bus.mst_req_o.q_valid, 1'b1);
      chk1("lk_qrdy2", bus.slv_rsp_o[2].q_ready, 1'b0);
      tick();
    end
    bus.mst_rsp_i.q_ready = 1'b1;
    #1;
    chk("lk_acc_addr", bus.mst_req_o.q.addr, 32'h1000);
    chk1("lk_acc_qrdy2", bus.slv_rsp_o[2].q_ready, 1'b1);
    chk1("lk_acc_qrdy0", bus.slv_rsp_o[0].q_ready, 1'b0);
    tick();
    req(2'd2, 32'h1004);
    #1;
    chk("lk_next_addr", bus.mst_req_o.q.addr, 32'h2000);
    chk1("lk_next_qrdy0", bus.slv_rsp_o[0].q_ready, 1'b1);
    tick();
    idle();

    // Response stall: owner FIFO holds {2, 0}; pop 2, then hold head 0.
    rsp(1'b1, 32'hF002);
    #1;
    chk("st_out_a", 32'(outstanding), 32'd2);
    chk1("st_pvld2", bus.slv_rsp_o[2].p_valid, 1'b1);
    tick();
    bus.slv_req_i[0].p_ready = 1'b0;
    rsp(1'b1, 32'hF000);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1("st_mst_prdy", bus.mst_req_o.p_ready, 1'b0);
      chk1("st_pvld0", bus.slv_rsp_o[0].p_valid, 1'b1);
      chk1("st_pvld1", bus.slv_rsp_o[1].p_valid, 1'b0);
      chk("st_out", 32'(outstanding), 32'd1);
      tick();
    end
    bus.slv_req_i[0].p_ready = 1'b1;
    #1;
    chk1("st_rel_prdy", bus.mst_req_o.p_ready, 1'b1);
    tick();
    rsp(1'b0, 32'h0);
    #1;
    chk("st_out_end", 32'(outstanding), 32'd0);

    // Full: four accepts, fifth blocked until the cycle after a pop.
    for (int c = 0; c < 4; c++) begin
      req(2'd1, 32'h300 + 32'(c) * 4);
      #1;
      chk1("fu_qvld", bus.mst_req_o.q_valid, 1'b1);
      chk("fu_out", 32'(outstanding), 32'(c));
      tick();
    end
    req(2'd1, 32'h310);
    #1;
    chk("fu_out_full", 32'(outstanding), 32'd4);
    chk1("fu_qvld_blk", bus.mst_req_o.q_valid, 1'b0);
    chk1("fu_qrdy_blk", bus.slv_rsp_o[1].q_ready, 1'b0);
    tick();
    rsp(1'b1, 32'h0000_00AA);
    #1;
    chk1("fu_qvld_popcyc", bus.mst_req_o.q_valid, 1'b0);
    chk1("fu_pvld1", bus.slv_rsp_o[1].p_valid, 1'b1);
    tick();
    rsp(1'b0, 32'h0);
    #1;
    chk("fu_out_after_pop", 32'(outstanding), 32'd3);
    chk1("fu_qvld_after", bus.mst_req_o.q_valid, 1'b1);
    chk("fu_addr_after", bus.mst_req_o.q.addr, 32'h310);
    tick();
    idle();
    #1;
    chk("fu_out_refill", 32'(outstanding), 32'd4);

    // Reset with two outstanding, then a late response is dropped as unexpected.
    rsp(1'b1, 32'hB0);
    tick();
    tick();
    rsp(1'b0, 32'h0);
    #1;
    chk("ur_out_pre", 32'(outstanding), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("ur_out_rst", 32'(outstanding), 32'd0);
    rsp(1'b1, 32'hBAD);
    #1;
    chk1("ur_prdy", bus.mst_req_o.p_ready, 1'b1);
    chk1("ur_pulse", unexpected, 1'b1);
    chk1("ur_pvld", bus.slv_rsp_o[0].p_valid | bus.slv_rsp_o[1].p_valid | bus.slv_rsp_o[2].p_valid, 1'b0);
    tick();
    rsp(1'b0, 32'h0);
    #1;
    chk1("ur_pulse_end", unexpected, 1'b0);
    chk("ur_out_end", 32'(outstanding), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
